uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter (`uart_top`: `send_go`/`data`/`Baudrate_Set` in, `Tx_Done` out) among up to N byte producers. It grants one requester at a time and latches that requester's byte. It issues a single-cycle `send_go`, holds `data` stable until `Tx_Done`, and enforces an inter-byte guard gap. A watchdog recovers the block if `Tx_Done` never arrives. It sits between test/data generators and `uart_top` in the TX path.

## Interface
- N_REQ, 4, number of requesters (2..8)
- GAP_CYCLES, 16, idle cycles after each frame before the next grant (0 = none)
- TIMEOUT, 1_000_000, max cycles to wait for `Tx_Done` after `send_go` (≥2)
- BAUD_RST, 3'd4, reset value of `Baudrate_Set`

- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- req  in  N_REQ  level request per requester; held with `req_data` until its `ack`
- req_data  in  8*N_REQ  byte of requester i on bits [8i+7:8i]
- cfg_baud  in  3  baud select; applied only while IDLE
- ack  out  N_REQ  one-cycle pulse: byte of requester i accepted
- done  out  N_REQ  one-cycle pulse: requester i's frame completed (`Tx_Done` seen)
- err  out  N_REQ  one-cycle pulse: requester i's frame timed out
- busy  out  1  high in any state other than IDLE
- send_go  out  1  to uart_top; one-cycle start pulse
- data  out  8  to uart_top; latched byte, stable from `send_go` until frame end
- Baudrate_Set  out  3  to uart_top
- Tx_Done  in  1  from uart_top; one-cycle frame-complete pulse

## Operation
- All outputs are registered. Reset values: ack/done/err = 0, busy = 0, send_go = 0, data = 8'd0, Baudrate_Set = BAUD_RST. Internally, state = IDLE, rr pointer = 0, counters = 0.
- States: IDLE, BUSY, GAP.
- IDLE:
  - `Baudrate_Set <= cfg_baud` every cycle.
  - If `req != 0`, grant the first set bit searching from `ptr` upward, modulo N_REQ. In that cycle: `data <= req_data[grant]`, `cur <= grant`, `ack[grant] <= 1`, `send_go <= 1`, `ptr <= (grant+1) mod N_REQ`, `tcnt <= 0`, go to BUSY.
- BUSY:
  - `send_go` returns to 0 after one cycle. `tcnt` increments each cycle.
  - If `Tx_Done`: `done[cur] <= 1` and go to GAP, or to IDLE when GAP_CYCLES = 0.
  - Otherwise, if `tcnt == TIMEOUT-1`: `err[cur] <= 1` and take the same exit. The byte is dropped, not retried.
  - `Tx_Done` has priority over timeout when both occur in the same cycle.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Requests are not sampled in GAP.
- `Tx_Done` seen in IDLE or GAP is ignored and generates no `done`.
- `req[i]` still high after its `ack` counts as a new request. That requester's next byte is granted only after the other pending requesters have been served (fairness).
- `cfg_baud` changes during BUSY/GAP take effect at the next IDLE cycle. The baud never changes mid-frame.
- Reset mid-frame: everything returns to reset values immediately. The in-flight byte is abandoned with no `done` or `err`.
- Counter widths: `tcnt` = $clog2(TIMEOUT+1), gap counter = $clog2(GAP_CYCLES+1). The pointer wraps from N_REQ-1 to 0.

## Timing
- Grant latency: a request sampled at edge E while IDLE produces `ack` and `send_go` both high during the cycle after E.
- `data` is valid in the same cycle as `send_go` and is unchanged until the next grant.
- `Tx_Done` high at edge F produces `done` high in the cycle after F.
- Next grant: earliest at edge F+GAP_CYCLES+1, so back-to-back `send_go` pulses are at least GAP_CYCLES+2 cycles apart.
- At most one bit of ack, done and err is set per cycle, and `ack` and `done` are never high in the same cycle.

## Test plan
Bench settings: N_REQ=4, GAP_CYCLES=2, TIMEOUT=100. The `uart_top` model pulses `Tx_Done` 20 cycles after `send_go` unless disabled.

- Single request, `req=4'b0010`, `req_data[15:8]=8'hA5`: `ack=4'b0010` and `send_go` pulse in the same cycle with `data=8'hA5`; `done=4'b0010` one cycle after `Tx_Done`; `busy` returns to 0 two cycles after `done`.
- All four requesters held high continuously with bytes 8'h10/11/12/13: grant order 0,1,2,3,0 with data 10,11,12,13,10; consecutive `send_go` pulses exactly 24 cycles apart.
- Model disabled (no `Tx_Done`), `req=4'b1000`: `err=4'b1000` pulses 100 cycles after `send_go`, with no `done`; the next request is granted normally.
- `cfg_baud` changed from 4 to 2 during BUSY: `Baudrate_Set` stays 4 until the frame and gap finish, then becomes 2 in the first IDLE cycle.
- `rstn` asserted 5 cycles after `send_go`: all outputs go to reset values at once, including `Baudrate_Set=3'd4`; the stray `Tx_Done` after release produces no `done`; the next grant starts from requester 0.
- Same-cycle `Tx_Done` and timeout (model delay = 99 cycles): only `done` fires, with no `err`.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_top-side signals of the shared UART TX arbiter.
// master = producers plus uart_top model, slave = the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [2:0]         cfg_baud;
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   done;
    logic [N_REQ-1:0]   err;
    logic               busy;
    logic               send_go;
    logic [7:0]         data;
    logic [2:0]         Baudrate_Set;
    logic               Tx_Done;

    modport master (
        output req, req_data, cfg_baud, Tx_Done,
        input  ack, done, err, busy, send_go, data, Baudrate_Set
    );

    modport slave (
        input  req, req_data, cfg_baud, Tx_Done,
        output ack, done, err, busy, send_go, data, Baudrate_Set
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_top transmitter among N_REQ
// byte producers, with inter-frame guard gap and Tx_Done watchdog.
module uart_tx_arbiter #(
    parameter int         N_REQ      = 4,
    parameter int         GAP_CYCLES = 16,
    parameter int         TIMEOUT    = 1_000_000,
    parameter logic [2:0] BAUD_RST   = 3'd4
) (
    input logic             clk,
    input logic             rstn,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PW-1:0] P_LAST = PW'(N_REQ - 1);
    localparam logic [PW:0]   P_N    = (PW+1)'(N_REQ);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t         state;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  cur;
    logic [TW-1:0]  tcnt;
    logic [GW-1:0]  gcnt;
    logic [PW-1:0]  grant;
    logic [PW-1:0]  idx;
    logic [PW:0]    sum;
    logic           hit;

    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] i);
        onehot = '0;
        onehot[i] = 1'b1;
    endfunction

    // First set request at or above ptr, wrapping modulo N_REQ.
    always_comb begin
        grant = '0;
        hit   = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= P_N) sum = sum - P_N;
            idx = sum[PW-1:0];
            if (!hit && bus.req[idx]) begin
                hit   = 1'b1;
                grant = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            ptr              <= '0;
            cur              <= '0;
            tcnt             <= '0;
            gcnt             <= '0;
            bus.ack          <= '0;
            bus.done         <= '0;
            bus.err          <= '0;
            bus.busy         <= 1'b0;
            bus.send_go      <= 1'b0;
            bus.data         <= '0;
            bus.Baudrate_Set <= BAUD_RST;
        end else begin
            bus.ack     <= '0;
            bus.done    <= '0;
            bus.err     <= '0;
            bus.send_go <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.Baudrate_Set <= bus.cfg_baud;
                    if (hit) begin
                        bus.data    <= bus.req_data[{grant, 3'b000} +: 8];
                        bus.ack     <= onehot(grant);
                        bus.send_go <= 1'b1;
                        bus.busy    <= 1'b1;
                        cur         <= grant;
                        ptr         <= (grant == P_LAST) ? '0 : grant + 1'b1;
                        tcnt        <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    tcnt <= tcnt + 1'b1;
                    // Tx_Done wins over a coincident timeout.
                    if (bus.Tx_Done || tcnt == T_LAST) begin
                        if (bus.Tx_Done) bus.done <= onehot(cur);
                        else             bus.err  <= onehot(cur);
                        gcnt <= '0;
                        if (GAP_CYCLES == 0) begin
                            state            <= IDLE;
                            bus.busy         <= 1'b0;
                            bus.Baudrate_Set <= bus.cfg_baud;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gcnt == G_LAST) begin
                        state            <= IDLE;
                        bus.busy         <= 1'b0;
                        bus.Baudrate_Set <= bus.cfg_baud;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int GAP = 2;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ(N),
        .GAP_CYCLES(GAP),
        .TIMEOUT(TMO),
        .BAUD_RST(3'd4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int tick = 0;
    bit run_cmp = 1'b0;

    always @(posedge clk) tick <= tick + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // uart_top stand-in: Tx_Done pulses uart_delay cycles after send_go.
    bit uart_en = 1'b1;
    int uart_delay = 20;
    int ucnt = -1;
    always @(posedge clk) begin
        #2;
        if (ucnt >= 0) ucnt--;
        if (bus.send_go === 1'b1 && uart_en) ucnt = uart_delay;
        bus.Tx_Done = (ucnt == 0);
    end

    // Reference model: frame-level bookkeeping with cycle timestamps.
    int m_n = 0;
    int m_start = 0;
    int m_next = 0;
    int m_ptr = 0;
    int m_cur = 0;
    bit m_active = 1'b0;
    logic [N-1:0] m_ack = '0;
    logic [N-1:0] m_done = '0;
    logic [N-1:0] m_err = '0;
    logic m_go = 1'b0;
    logic m_busy = 1'b0;
    logic [7:0] m_data = '0;
    logic [2:0] m_baud = 3'd4;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_n = 0; m_start = 0; m_next = 0; m_ptr = 0; m_cur = 0;
            m_active = 1'b0;
            m_ack = '0; m_done = '0; m_err = '0;
            m_go = 1'b0; m_busy = 1'b0; m_data = '0; m_baud = 3'd4;
        end else begin
            m_n++;
            m_ack = '0; m_done = '0; m_err = '0; m_go = 1'b0;
            if (m_active) begin
                if (bus.Tx_Done) begin
                    m_done[m_cur] = 1'b1;
                    m_active = 1'b0;
                    m_next = m_n + GAP + 1;
                end else if (m_n - m_start == TMO) begin
                    m_err[m_cur] = 1'b1;
                    m_active = 1'b0;
                    m_next = m_n + GAP + 1;
                end
            end
            if (!m_active && m_n >= m_next - 1) m_baud = bus.cfg_baud;
            if (!m_active && m_n >= m_next && bus.req != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_active && bus.req[(m_ptr + k) % N]) begin
                        m_cur = (m_ptr + k) % N;
                        m_active = 1'b1;
                    end
                end
                m_ack[m_cur] = 1'b1;
                m_go = 1'b1;
                m_data = bus.req_data[8*m_cur +: 8];
                m_ptr = (m_cur + 1) % N;
                m_start = m_n;
            end
            m_busy = m_active || (m_n < m_next - 1);
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("ack", 32'(bus.ack), 32'(m_ack));
            check("done", 32'(bus.done), 32'(m_done));
            check("err", 32'(bus.err), 32'(m_err));
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("send_go", 32'(bus.send_go), 32'(m_go));
            check("data", 32'(bus.data), 32'(m_data));
            check("baud", 32'(bus.Baudrate_Set), 32'(m_baud));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic sig_hit(input int kind);
        case (kind)
            0: return bus.ack != 0;
            1: return bus.done != 0;
            2: return bus.err != 0;
            3: return !bus.busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int kind, input int bound, input string nm);
        int k = 0;
        @(negedge clk);
        while (!sig_hit(kind) && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (!sig_hit(kind)) begin
            total++;
            bad++;
            $display("FAIL %s: no event within %0d cycles, event required", nm, bound);
        end
    endtask

    task automatic do_reset();
        step();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    int t0, t1, cnt, r;
    int ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req = '0;
        bus.req_data = '0;
        bus.cfg_baud = 3'd4;
        repeat (3) @(posedge clk);
        #2;
        run_cmp = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_baud", 32'(bus.Baudrate_Set), 32'd4);
        check("rst_data", 32'(bus.data), 32'd0);
        step();
        rstn = 1'b1;

        // single request from requester 1
        step();
        bus.req = 4'b0010;
        bus.req_data[15:8] = 8'hA5;
        wait_for(0, 10, "t1_ack");
        t0 = tick;
        check("t1_ack", 32'(bus.ack), 32'h2);
        check("t1_go", 32'(bus.send_go), 32'd1);
        check("t1_data", 32'(bus.data), 32'hA5);
        step();
        bus.req = '0;
        wait_for(1, 200, "t1_done");
        check("t1_done", 32'(bus.done), 32'h2);
        check("t1_done_lat", 32'(tick - t0), 32'd21);
        t1 = tick;
        wait_for(3, 20, "t1_idle");
        check("t1_idle_lat", 32'(tick - t1), 32'd2);

        // four requesters held continuously
        do_reset();
        bus.req_data = 32'h13121110;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_for(0, 100, "t2_ack");
            check("t2_ack", 32'(bus.ack), 32'(4'b0001 << ord[k]));
            check("t2_data", 32'(bus.data), 32'(8'h10 + ord[k]));
            if (k > 0) check("t2_space", 32'(tick - t0), 32'd24);
            t0 = tick;
        end
        step();
        bus.req = '0;
        wait_for(3, 100, "t2_idle");

        // timeout with uart_top silent, then normal grant
        uart_en = 1'b0;
        step();
        bus.req = 4'b1000;
        bus.req_data[31:24] = 8'h3C;
        wait_for(0, 20, "t3_ack");
        t0 = tick;
        step();
        bus.req = '0;
        wait_for(2, 150, "t3_err");
        check("t3_err", 32'(bus.err), 32'h8);
        check("t3_err_lat", 32'(tick - t0), 32'd100);
        check("t3_nodone", 32'(bus.done), 32'd0);
        uart_en = 1'b1;
        step();
        bus.req = 4'b0001;
        bus.req_data[7:0] = 8'h5A;
        wait_for(0, 20, "t3_ack2");
        check("t3_ack2", 32'(bus.ack), 32'h1);
        step();
        bus.req = '0;
        wait_for(1, 100, "t3_done2");
        wait_for(3, 20, "t3_idle");

        // baud change while busy
        step();
        bus.req = 4'b0100;
        bus.req_data[23:16] = 8'hC3;
        wait_for(0, 20, "t4_ack");
        step();
        bus.req = '0;
        bus.cfg_baud = 3'd2;
        wait_for(1, 100, "t4_done");
        check("t4_baud_busy", 32'(bus.Baudrate_Set), 32'd4);
        wait_for(3, 20, "t4_idle");
        check("t4_baud_idle", 32'(bus.Baudrate_Set), 32'd2);

        // reset mid-frame
        step();
        bus.req = 4'b0010;
        bus.req_data[15:8] = 8'h77;
        wait_for(0, 20, "t5_ack");
        repeat (5) step();
        rstn = 1'b0;
        bus.req = '0;
        @(negedge clk);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_data", 32'(bus.data), 32'd0);
        check("t5_baud", 32'(bus.Baudrate_Set), 32'd4);
        step();
        step();
        rstn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done != 0) cnt++;
        end
        check("t5_stray", 32'(cnt), 32'd0);
        step();
        bus.req = 4'b1001;
        bus.req_data = 32'hEE0000DD;
        wait_for(0, 20, "t5_ack2");
        check("t5_ack2", 32'(bus.ack), 32'h1);
        check("t5_data2", 32'(bus.data), 32'hDD);
        step();
        bus.req = '0;
        wait_for(1, 100, "t5_done2");
        wait_for(3, 20, "t5_idle");

        // Tx_Done coincides with timeout
        uart_delay = 99;
        step();
        bus.req = 4'b0100;
        wait_for(0, 20, "t6_ack");
        t0 = tick;
        step();
        bus.req = '0;
        wait_for(1, 150, "t6_done");
        check("t6_done", 32'(bus.done), 32'h4);
        check("t6_lat", 32'(tick - t0), 32'd100);
        check("t6_noerr", 32'(bus.err), 32'd0);
        wait_for(3, 20, "t6_idle");
        uart_delay = 20;

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            step();
            if ($urandom_range(0, 599) == 0) begin
                rstn = 1'b0;
                step();
                rstn = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    if (bus.ack[i]) begin
                        if ($urandom_range(0, 1) == 1)
                            bus.req_data[8*i +: 8] = 8'($urandom);
                        else
                            bus.req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.req_data[8*i +: 8] = 8'($urandom);
                end
            end
            if ($urandom_range(0, 63) == 0) bus.cfg_baud = 3'($urandom);
            uart_en = ($urandom_range(0, 19) != 0);
            r = $urandom_range(0, 9);
            uart_delay = (r == 0) ? 99 : $urandom_range(0, 30);
        end
        step();
        bus.req = '0;
        uart_en = 1'b1;
        repeat (150) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, finish required");
        $fatal(1, "watchdog");
    end
endmodule
